// File: rtl/zjh_seq_pkg.sv
// Shared constants for the zjh_74HC194 shift sequencer: FSM state codes and register mode codes.
package zjh_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    // Mode pins for an active shift in the latched direction.
    function automatic logic [1:0] shift_mode(input logic left);
        return left ? S_LEFT : S_RIGHT;
    endfunction

endpackage

// File: rtl/zjh_seq_bitcnt.sv
// Shift counter modelled on the 74HC161: synchronous clear, count enable, async active-low master reset.
module zjh_seq_bitcnt #(
    parameter int CW = 3
) (
    input  logic          Clk,
    input  logic          MR_N,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q
);

    logic [CW-1:0] q_q;
    logic [CW-1:0] q_d;

    // Clear has priority over count, like the 161's synchronous load-to-zero.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = q_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge MR_N) begin
        if (!MR_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/zjh_shift_seq.sv
// Sequencer for a zjh_74HC194: parallel-load, shift len places, pulse done.
// Define ZJH_SHIFT_ROTATE_EN to feed ser_fb back into DSR/DSL during SHIFT (rotate instead of fill).
module zjh_shift_seq
    import zjh_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic          Clk,
    input  logic          MR_N,
    input  logic          req,
    input  logic          dir,
    input  logic [CW-1:0] len,
    input  logic          hold,
    input  logic          fill,
    input  logic          ser_fb,
    output logic [1:0]    S,
    output logic          DSR,
    output logic          DSL,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LEN_MAX = CW'(WIDTH);

    logic [1:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] len_q, len_d;
    logic          fill_q, fill_d;
    logic          cnt_clr;
    logic          cnt_en;
    logic          fill_src;

    zjh_seq_bitcnt #(
        .CW (CW)
    ) u_bitcnt (
        .Clk  (Clk),
        .MR_N (MR_N),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .q    (cnt)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        len_d   = len_q;
        fill_d  = fill_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    dir_d   = dir;
                    len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    fill_d  = fill;
                    cnt_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (len_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                // Exit on the edge that brings cnt up to len_q, so cnt stops at len_q.
                if (!hold) begin
                    cnt_en = 1'b1;
                    if (cnt + CW'(1) == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            len_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        S = S_HOLD;
        case (state_q)
            ST_LOAD:  S = S_LOAD;
            ST_SHIFT: S = hold ? S_HOLD : shift_mode(dir_q);
            default:  S = S_HOLD;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

`ifdef ZJH_SHIFT_ROTATE_EN
    assign fill_src = (state_q == ST_SHIFT) ? ser_fb : fill_q;
`else
    logic unused_ser_fb;
    assign unused_ser_fb = ser_fb;
    assign fill_src      = fill_q;
`endif

    // Both serial inputs carry the same source; the register only listens to the one its mode selects.
    assign DSR = fill_src;
    assign DSL = fill_src;

endmodule

// File: tb/tb_zjh_shift_seq.sv
// Directed bench for zjh_shift_seq driving a behavioural zjh_74HC194 register loaded with 4'b0110.
module tb_zjh_shift_seq;

    localparam int CW = 3;
    localparam logic [3:0] REG_IN = 4'b0110;

    logic          Clk = 1'b0;
    logic          MR_N;
    logic          req;
    logic          dir;
    logic [CW-1:0] len;
    logic          hold;
    logic          fill;
    logic          ser_fb;
    logic [1:0]    S;
    logic          DSR;
    logic          DSL;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    logic [3:0]    out_q;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    zjh_shift_seq #(
        .WIDTH (4),
        .CW    (CW)
    ) dut (
        .Clk    (Clk),
        .MR_N   (MR_N),
        .req    (req),
        .dir    (dir),
        .len    (len),
        .hold   (hold),
        .fill   (fill),
        .ser_fb (ser_fb),
        .S      (S),
        .DSR    (DSR),
        .DSL    (DSL),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    // Behavioural 74HC194: Out[3] receives DSR on a right shift, Out[0] receives DSL on a left shift.
    always @(posedge Clk or negedge MR_N) begin
        if (!MR_N) begin
            out_q <= 4'b0000;
        end else begin
            case (S)
                2'b11:   out_q <= REG_IN;
                2'b01:   out_q <= {DSR, out_q[3:1]};
                2'b10:   out_q <= {out_q[2:0], DSL};
                default: out_q <= out_q;
            endcase
        end
    end

    assign ser_fb = (S == 2'b10) ? out_q[3] : out_q[0];

    task automatic test_reset();
        MR_N = 1'b0; req = 1'b0; dir = 1'b0; len = 3'd0; hold = 1'b0; fill = 1'b0;
        #2;
        checks++;
        if ({S, DSR, DSL, busy, done, cnt} !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: S=%b DSR=%b DSL=%b busy=%b done=%b cnt=%0d, want all zero",
                     S, DSR, DSL, busy, done, cnt);
        end
        // Release at t=12, accept at 15, LOAD 15-25, first shift edge at 35.
        #10; MR_N = 1'b1; req = 1'b1; dir = 1'b0; len = 3'd4; fill = 1'b0;
        #8;  req = 1'b0;
        #16;
        checks++;
        if ({S, busy, cnt} !== {2'b01, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL reset_pre_shift: S=%b busy=%b cnt=%0d, want S=01 busy=1 cnt=1", S, busy, cnt);
        end
        #1; MR_N = 1'b0;
        #1;
        checks++;
        if ({S, busy, done, cnt} !== {2'b00, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_async: S=%b busy=%b done=%b cnt=%0d, want 00/0/0/0", S, busy, done, cnt);
        end
        #4; MR_N = 1'b1;
        @(negedge Clk);
        checks++;
        if ({S, busy} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle_after: S=%b busy=%b, want 00/0", S, busy);
        end
        $display("job reset: mid-shift reset observed");
    endtask

    task automatic test_right_shift();
        logic [1:0] exp_s   [0:3] = '{2'b11, 2'b01, 2'b01, 2'b00};
        logic [3:0] exp_out [0:3] = '{4'b0000, 4'b0110, 4'b1011, 4'b1101};
        @(negedge Clk);
        req = 1'b1; dir = 1'b0; len = 3'd2; fill = 1'b1; hold = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            if (c == 0) req = 1'b0;
            // Changes after accept must not disturb the running job.
            if (c == 1) begin dir = 1'b1; len = 3'd0; fill = 1'b0; end
            #1;
            checks++;
            if (S !== exp_s[c]) begin
                errors++;
                $display("FAIL right_S c%0d: got %b want %b", c, S, exp_s[c]);
            end
            checks++;
            if ({done, busy} !== {(c == 3), 1'b1}) begin
                errors++;
                $display("FAIL right_done_busy c%0d: got %b%b want %b1", c, done, busy, (c == 3));
            end
            if (c > 0) begin
                checks++;
                if (out_q !== exp_out[c]) begin
                    errors++;
                    $display("FAIL right_out c%0d: got %b want %b", c, out_q, exp_out[c]);
                end
            end
            if (c == 1) begin
                checks++;
                if ({DSR, DSL} !== 2'b11) begin
                    errors++;
                    $display("FAIL right_fill: DSR/DSL=%b%b want 11", DSR, DSL);
                end
            end
        end
        checks++;
        if (cnt !== 3'd2) begin
            errors++;
            $display("FAIL right_cnt: got %0d want 2", cnt);
        end
        @(negedge Clk);
        checks++;
        if ({S, busy, done} !== {2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL right_idle: S=%b busy=%b done=%b want 00/0/0", S, busy, done);
        end
        $display("job right_shift: len=2 fill=1 out=%b", out_q);
    endtask

    task automatic test_hold();
        logic [1:0]    exp_s   [0:7] = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [CW-1:0] exp_cnt [0:7] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        logic          hold_v  [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge Clk);
        req = 1'b1; dir = 1'b1; len = 3'd4; fill = 1'b0; hold = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (c == 0) req = 1'b0;
            hold = hold_v[c];
            #1;
            checks++;
            if (S !== exp_s[c]) begin
                errors++;
                $display("FAIL hold_S c%0d: got %b want %b", c, S, exp_s[c]);
            end
            checks++;
            if (done !== (c == 7)) begin
                errors++;
                $display("FAIL hold_done c%0d: got %b want %b", c, done, (c == 7));
            end
            checks++;
            if (cnt !== exp_cnt[c]) begin
                errors++;
                $display("FAIL hold_cnt c%0d: got %0d want %0d", c, cnt, exp_cnt[c]);
            end
        end
        hold = 1'b0;
        checks++;
        if (out_q !== 4'b0000) begin
            errors++;
            $display("FAIL hold_out: got %b want 0000", out_q);
        end
        @(negedge Clk);
        $display("job hold_left: len=4 two holds cnt=%0d out=%b", cnt, out_q);
    endtask

    task automatic test_len_edges();
        int shifts;
        @(negedge Clk);
        req = 1'b1; dir = 1'b0; len = 3'd0; fill = 1'b1;
        @(negedge Clk); req = 1'b0;
        checks++;
        if (S !== 2'b11) begin
            errors++;
            $display("FAIL len0_load: S=%b want 11", S);
        end
        @(negedge Clk);
        checks++;
        if ({S, done, cnt} !== {2'b00, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL len0_done: S=%b done=%b cnt=%0d want 00/1/0", S, done, cnt);
        end
        checks++;
        if (out_q !== REG_IN) begin
            errors++;
            $display("FAIL len0_out: got %b want %b", out_q, REG_IN);
        end
        @(negedge Clk);
        $display("job len0: load then done");

        req = 1'b1; dir = 1'b0; len = 3'd7; fill = 1'b0;
        shifts = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (c == 0) req = 1'b0;
            if (S == 2'b01) shifts++;
            checks++;
            if (done !== (c == 5)) begin
                errors++;
                $display("FAIL len7_done c%0d: got %b want %b", c, done, (c == 5));
            end
        end
        checks++;
        if (shifts !== 4) begin
            errors++;
            $display("FAIL len7_shifts: got %0d want 4", shifts);
        end
        checks++;
        if ({cnt, out_q} !== {3'd4, 4'b0000}) begin
            errors++;
            $display("FAIL len7_final: cnt=%0d out=%b want 4/0000", cnt, out_q);
        end
        @(negedge Clk);
        $display("job len7: clamped to %0d shifts", shifts);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_s [0:12] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00,
                                     2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [1:0] exp_s2 [0:5] = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        logic exp_done, exp_busy;
        @(negedge Clk);
        req = 1'b1; dir = 1'b0; len = 3'd1; fill = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge Clk);
            if (c == 10) req = 1'b0;
            exp_done = (c == 2) || (c == 6) || (c == 10);
            exp_busy = (c % 4 != 3) && (c < 11);
            checks++;
            if ({S, done, busy} !== {exp_s[c], exp_done, exp_busy}) begin
                errors++;
                $display("FAIL b2b c%0d: S/done/busy=%b/%b/%b want %b/%b/%b",
                         c, S, done, busy, exp_s[c], exp_done, exp_busy);
            end
        end
        $display("job back_to_back: three len=1 jobs");

        req = 1'b1; len = 3'd2;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            req = (c == 1);
            checks++;
            if ({S, done} !== {exp_s2[c], (c == 3)}) begin
                errors++;
                $display("FAIL req_ignored c%0d: S/done=%b/%b want %b/%b", c, S, done, exp_s2[c], (c == 3));
            end
        end
        req = 1'b0;
        $display("job req_pulse_in_shift: single job");
    endtask

    task automatic test_fill_source();
        logic [3:0] exp_out;
`ifdef ZJH_SHIFT_ROTATE_EN
        exp_out = REG_IN;
`else
        exp_out = 4'b1111;
`endif
        @(negedge Clk);
        req = 1'b1; dir = 1'b0; len = 3'd4; fill = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (c == 0) req = 1'b0;
        end
        checks++;
        if ({done, cnt} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL fill_done: done=%b cnt=%0d want 1/4", done, cnt);
        end
        checks++;
        if (out_q !== exp_out) begin
            errors++;
            $display("FAIL fill_out: got %b want %b", out_q, exp_out);
        end
        @(negedge Clk);
        $display("job fill_source: len=4 right out=%b", out_q);
    endtask

    initial begin
        test_reset();
        test_right_shift();
        test_hold();
        test_len_edges();
        test_back_to_back();
        test_fill_source();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
